leaf_out_arbiter: RTL and testbench

- Shares the single 49-bit leaf-to-BFT output link among the NUM_OUT_PORTS user output streams of a leaf.
- Uses round-robin arbitration gated by per-port credit (downstream freespace) counters.
- Wraps each granted 32-bit payload into a BFT packet using a per-port route table and a per-port sequence address.
- Sits between the user kernel output ports and the leaf interface packet output, in the fast leaf clock domain.

---
 rtl/leaf_out_arbiter.sv | 160 ++++++++++++++++
 tb/tb_leaf_out_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_out_arbiter.sv
// Round-robin, credit-gated arbiter that shares the leaf output link among the
// user output streams and wraps each granted word into a routed BFT packet.
module leaf_out_arbiter #(
  parameter int unsigned NUM_OUT_PORTS = 7,
  parameter int unsigned PAYLOAD_BITS  = 32,
  parameter int unsigned NUM_LEAF_BITS = 5,
  parameter int unsigned NUM_PORT_BITS = 4,
  parameter int unsigned NUM_ADDR_BITS = 7,
  parameter int unsigned CREDIT_BITS   = 8,
  parameter int unsigned CREDIT_INIT   = 128,
  parameter int unsigned PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user,
  output logic [NUM_OUT_PORTS-1:0]              ack_user,
  input  logic                                  resend,
  input  logic                                  cfg_we,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dport,
  input  logic                                  cfg_en,
  input  logic                                  credit_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_port,
  input  logic [CREDIT_BITS-1:0]                credit_cnt,
  output logic [PACKET_BITS-1:0]                pkt_out,
  output logic                                  busy
);

  localparam int unsigned PTR_BITS = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int unsigned SUM_BITS = CREDIT_BITS + 2;

  typedef struct packed {
    logic                     vld;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] dport;
    logic [NUM_ADDR_BITS-1:0] addr;
    logic [PAYLOAD_BITS-1:0]  payload;
  } pkt_t;

  logic [NUM_OUT_PORTS-1:0] en_q, en_d;
  logic [NUM_LEAF_BITS-1:0] leaf_q   [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] leaf_d   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dport_q  [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dport_d  [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_q [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_d [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_q    [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_d    [NUM_OUT_PORTS];
  logic [PTR_BITS-1:0]      ptr_q, ptr_d;
  pkt_t                     pkt_q, pkt_d;
  logic                     busy_q, busy_d;

  logic [NUM_OUT_PORTS-1:0] elig_c;
  logic [NUM_OUT_PORTS-1:0] grant_c;
  logic [PTR_BITS:0]        scan_sum;
  logic [PTR_BITS-1:0]      scan_idx;
  logic                     found;
  logic [SUM_BITS-1:0]      credit_sum;

  // A port may win only with data, an enabled route, credit left and no link stall
  always_comb begin
    elig_c = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      elig_c[i] = vld_user[i] & en_q[i] & (credit_q[i] != '0) & ~resend;
    end
  end

  // Round-robin scan starting at ptr_q and wrapping; first eligible port wins
  always_comb begin
    grant_c  = '0;
    found    = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
      scan_sum = {1'b0, ptr_q} + (PTR_BITS+1)'(k);
      if (scan_sum >= (PTR_BITS+1)'(NUM_OUT_PORTS)) begin
        scan_sum = scan_sum - (PTR_BITS+1)'(NUM_OUT_PORTS);
      end
      scan_idx = scan_sum[PTR_BITS-1:0];
      if (!found && elig_c[scan_idx]) begin
        found             = 1'b1;
        grant_c[scan_idx] = 1'b1;
      end
    end
  end

  assign ack_user = grant_c;

  // Next state: packet build, credit/seq bookkeeping; config write overrides both
  always_comb begin
    en_d       = en_q;
    leaf_d     = leaf_q;
    dport_d    = dport_q;
    credit_d   = credit_q;
    seq_d      = seq_q;
    ptr_d      = ptr_q;
    pkt_d      = '0;
    busy_d     = 1'b0;
    credit_sum = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      busy_d = busy_d | (vld_user[i] & en_q[i] & (credit_q[i] == '0));
      if (grant_c[i]) begin
        pkt_d.vld     = 1'b1;
        pkt_d.leaf    = leaf_q[i];
        pkt_d.dport   = dport_q[i];
        pkt_d.addr    = seq_q[i];
        pkt_d.payload = din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        seq_d[i]      = seq_q[i] + NUM_ADDR_BITS'(1);
        ptr_d         = (i == NUM_OUT_PORTS - 1) ? '0 : PTR_BITS'(i + 1);
      end
      if (en_q[i]) begin
        credit_sum = SUM_BITS'(credit_q[i]) - SUM_BITS'(grant_c[i]);
        if (credit_vld && (credit_port == NUM_PORT_BITS'(i))) begin
          credit_sum = credit_sum + SUM_BITS'(credit_cnt);
        end
        if (credit_sum > SUM_BITS'(CREDIT_INIT)) begin
          credit_sum = SUM_BITS'(CREDIT_INIT);
        end
        credit_d[i] = credit_sum[CREDIT_BITS-1:0];
      end
      if (cfg_we && (cfg_port == NUM_PORT_BITS'(i))) begin
        en_d[i]     = cfg_en;
        leaf_d[i]   = cfg_leaf;
        dport_d[i]  = cfg_dport;
        credit_d[i] = CREDIT_BITS'(CREDIT_INIT);
        seq_d[i]    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q   <= '0;
      ptr_q  <= '0;
      pkt_q  <= '0;
      busy_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
        leaf_q[i]   <= '0;
        dport_q[i]  <= '0;
        credit_q[i] <= CREDIT_BITS'(CREDIT_INIT);
        seq_q[i]    <= '0;
      end
    end else begin
      en_q     <= en_d;
      leaf_q   <= leaf_d;
      dport_q  <= dport_d;
      credit_q <= credit_d;
      seq_q    <= seq_d;
      ptr_q    <= ptr_d;
      pkt_q    <= pkt_d;
      busy_q   <= busy_d;
    end
  end

  assign pkt_out = PACKET_BITS'(pkt_q);
  assign busy    = busy_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Randomized bench for leaf_out_arbiter against a per-port bookkeeping model.
module tb_leaf_out_arbiter;

  localparam int unsigned NP    = 7;
  localparam int unsigned PB    = 32;
  localparam int unsigned PKW   = 49;
  localparam int          CINIT = 128;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NP*PB-1:0] din_user;
  logic [NP-1:0]    vld_user;
  logic [NP-1:0]    ack_user;
  logic             resend;
  logic             cfg_we;
  logic [3:0]       cfg_port;
  logic [4:0]       cfg_leaf;
  logic [3:0]       cfg_dport;
  logic             cfg_en;
  logic             credit_vld;
  logic [3:0]       credit_port;
  logic [7:0]       credit_cnt;
  logic [PKW-1:0]   pkt_out;
  logic             busy;

  leaf_out_arbiter dut (
    .clk(clk), .reset_n(reset_n), .din_user(din_user), .vld_user(vld_user),
    .ack_user(ack_user), .resend(resend), .cfg_we(cfg_we), .cfg_port(cfg_port),
    .cfg_leaf(cfg_leaf), .cfg_dport(cfg_dport), .cfg_en(cfg_en),
    .credit_vld(credit_vld), .credit_port(credit_port), .credit_cnt(credit_cnt),
    .pkt_out(pkt_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference state, kept as plain integers per port
  bit             m_en     [NP];
  logic [4:0]     m_leaf   [NP];
  logic [3:0]     m_dport  [NP];
  int             m_credit [NP];
  int             m_seq    [NP];
  int             m_ptr;
  logic [PKW-1:0] exp_pkt;
  bit             exp_busy;

  int             tests_run;
  int             tests_failed;
  int             pkt_cnt;
  logic [PKW-1:0] last_pkt;
  logic [31:0]    first0;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_en[i] = 1'b0; m_leaf[i] = '0; m_dport[i] = '0;
      m_credit[i] = CINIT; m_seq[i] = 0;
    end
    m_ptr = 0; exp_pkt = '0; exp_busy = 1'b0;
  endtask

  task automatic set_idle();
    vld_user = '0; resend = 1'b0; cfg_we = 1'b0; cfg_port = '0; cfg_leaf = '0;
    cfg_dport = '0; cfg_en = 1'b0; credit_vld = 1'b0; credit_port = '0; credit_cnt = '0;
  endtask

  task automatic rand_din();
    for (int i = 0; i < NP; i++) din_user[i*PB +: PB] = $urandom();
  endtask

  // Called at posedge+1 with inputs applied; checks ack, advances the model, checks outputs after the edge
  task automatic tick();
    int g; int p; int cp; int c;
    logic [NP-1:0] ea;
    bit nb;
    #1;
    g = -1;
    if (!resend) begin
      for (int k = 0; k < NP; k++) begin
        p = (m_ptr + k) % NP;
        if (g < 0 && vld_user[p] && m_en[p] && m_credit[p] > 0) g = p;
      end
    end
    ea = '0;
    if (g >= 0) ea[g] = 1'b1;
    chk_eq("ack", 64'(ack_user), 64'(ea));
    nb = 1'b0;
    for (int i = 0; i < NP; i++) if (vld_user[i] && m_en[i] && m_credit[i] == 0) nb = 1'b1;
    exp_busy = nb;
    if (g >= 0) begin
      exp_pkt = {1'b1, m_leaf[g], m_dport[g], 7'(m_seq[g]), din_user[g*PB +: PB]};
      m_ptr = (g + 1) % NP;
      m_credit[g] = m_credit[g] - 1;
      m_seq[g] = (m_seq[g] + 1) % 128;
    end else begin
      exp_pkt = '0;
    end
    cp = int'(credit_port);
    if (credit_vld && cp < NP && m_en[cp]) begin
      c = m_credit[cp] + int'(credit_cnt);
      m_credit[cp] = (c > CINIT) ? CINIT : c;
    end
    cp = int'(cfg_port);
    if (cfg_we && cp < NP) begin
      m_en[cp] = cfg_en; m_leaf[cp] = cfg_leaf; m_dport[cp] = cfg_dport;
      m_credit[cp] = CINIT; m_seq[cp] = 0;
    end
    @(posedge clk); #1;
    chk_eq("pkt", 64'(pkt_out), 64'(exp_pkt));
    chk_eq("busy", 64'(busy), 64'(exp_busy));
    if (pkt_out[PKW-1]) begin
      pkt_cnt++;
      last_pkt = pkt_out;
    end
  endtask

  task automatic cfg_tick(input int port, input int lf, input int dp, input bit en);
    set_idle();
    cfg_we = 1'b1; cfg_port = 4'(port); cfg_leaf = 5'(lf); cfg_dport = 4'(dp); cfg_en = en;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; pkt_cnt = 0; last_pkt = '0;
    reset_n = 1'b0;
    set_idle();
    rand_din();
    vld_user = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_ack", 64'(ack_user), 64'd0);
    chk_eq("rst_pkt", 64'(pkt_out), 64'd0);
    chk_eq("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;

    // Three ports round-robin at full rate
    for (int i = 0; i < 3; i++) cfg_tick(i, 3, 1, 1'b1);
    set_idle();
    vld_user = '1;
    rand_din();
    first0 = din_user[31:0];
    tick();
    chk_eq("first_pkt", 64'(pkt_out), 64'({1'b1, 5'd3, 4'd1, 7'd0, first0}));
    for (int i = 0; i < 5; i++) begin rand_din(); tick(); end

    // Link stall during streaming
    vld_user = 7'h07;
    for (int i = 0; i < 9; i++) begin
      rand_din();
      resend = (i >= 3 && i < 6);
      tick();
    end
    resend = 1'b0;

    // Credit exhaustion on port 4, then a return of 5
    cfg_tick(4, 7, 2, 1'b1);
    set_idle();
    vld_user = 7'h10;
    pkt_cnt = 0;
    for (int i = 0; i < 130; i++) begin rand_din(); tick(); end
    chk_eq("p4_pkts", 64'(pkt_cnt), 64'd128);
    chk_eq("p4_busy", 64'(busy), 64'd1);
    #1;
    chk_eq("p4_noack", 64'(ack_user), 64'd0);
    credit_vld = 1'b1; credit_port = 4'd4; credit_cnt = 8'd5;
    pkt_cnt = 0;
    tick();
    credit_vld = 1'b0;
    for (int i = 0; i < 10; i++) begin rand_din(); tick(); end
    chk_eq("p4_ret5", 64'(pkt_cnt), 64'd5);
    vld_user = '0;

    // Sequence wrap with same-cycle grant and saturating return
    cfg_tick(5, 9, 3, 1'b1);
    set_idle();
    vld_user = 7'h20;
    credit_vld = 1'b1; credit_port = 4'd5; credit_cnt = 8'd10;
    pkt_cnt = 0;
    for (int i = 0; i < 129; i++) begin rand_din(); tick(); end
    chk_eq("wrap_cnt", 64'(pkt_cnt), 64'd129);
    chk_eq("wrap_seq", 64'(last_pkt[38:32]), 64'd0);
    cfg_we = 1'b1; cfg_port = 4'd5; cfg_leaf = 5'd9; cfg_dport = 4'd3; cfg_en = 1'b1;
    rand_din();
    tick();
    cfg_we = 1'b0;
    rand_din();
    tick();
    chk_eq("cfg_seq0", 64'(pkt_out[38:32]), 64'd0);
    set_idle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      rand_din();
      vld_user = 7'($urandom());
      resend = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) begin
        cfg_we = 1'b1; cfg_port = 4'($urandom_range(0, 8));
        cfg_leaf = 5'($urandom()); cfg_dport = 4'($urandom());
        cfg_en = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 9) < 3) begin
        credit_vld = 1'b1; credit_port = 4'($urandom_range(0, 8));
        credit_cnt = 8'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 199) == 0) credit_cnt = 8'hFF;
      tick();
    end

    // Asynchronous reset in the middle of a cycle
    cfg_tick(0, 1, 1, 1'b1);
    set_idle();
    vld_user = '1;
    rand_din();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk_eq("arst_ack", 64'(ack_user), 64'd0);
    chk_eq("arst_pkt", 64'(pkt_out), 64'd0);
    chk_eq("arst_busy", 64'(busy), 64'd0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    vld_user = '1;
    for (int i = 0; i < 3; i++) begin rand_din(); tick(); end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
